// File: rtl/memory_pkg.sv
// Shared definitions for the memory controller: FSM state encoding and word geometry.
package memory_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RESPOND = 2'd2
  } state_t;

  localparam int WORD_BITS        = 32;
  localparam int WORD_BYTES       = 4;
  localparam int BYTE_OFFSET_BITS = 2;

endpackage

// File: rtl/memory_controller_ram.sv
// Single-port backing RAM: synchronous write, combinational read, contents never reset.
module memory_controller_ram
  import memory_pkg::*;
#(
  parameter  int MEMORY_WORDS = 1024,
  localparam int ADDR_BITS    = $clog2(MEMORY_WORDS)
) (
  input  logic                 clock,
  input  logic                 write_enable,
  input  logic [ADDR_BITS-1:0] index,
  input  logic [WORD_BITS-1:0] write_data,
  output logic [WORD_BITS-1:0] read_data
);

  // Zero contents at time zero so simulation reads of unwritten words are defined.
  logic [WORD_BITS-1:0] mem [MEMORY_WORDS] = '{default: '0};

  always_ff @(posedge clock) begin
    if (write_enable) begin
      mem[index] <= write_data;
    end
  end

  assign read_data = mem[index];

endmodule

// File: rtl/memory_controller.sv
// Fixed-latency word memory responder below the L1 cache.
// Optional build macro MEMORY_CONTROLLER_RANGE_CHECK_EN adds an out-of-range error output.
module memory_controller
  import memory_pkg::*;
#(
  parameter int MEMORY_WORDS = 1024,
  parameter int LATENCY      = 4
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 request,
  input  logic [WORD_BITS-1:0] address,
  input  logic [WORD_BITS-1:0] input_data,
  input  logic                 should_write,
  output logic [WORD_BITS-1:0] output_data,
  output logic                 ready
`ifdef MEMORY_CONTROLLER_RANGE_CHECK_EN
  ,
  output logic                 error
`endif
);

  localparam int ADDR_BITS = $clog2(MEMORY_WORDS);
  localparam int CNT_BITS  = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  state_t               state;
  state_t               next_state;
  logic [CNT_BITS-1:0]  count;
  logic [ADDR_BITS-1:0] cap_index;
  logic [WORD_BITS-1:0] cap_data;
  logic                 cap_write;
  logic                 access;
  logic                 accept;
  logic                 ram_we;
  logic [WORD_BITS-1:0] ram_rdata;
  logic                 unused_bits;

  // Upper address bits alias away and byte-offset bits are ignored.
  assign unused_bits = ^{address[WORD_BITS-1:ADDR_BITS+BYTE_OFFSET_BITS],
                         address[BYTE_OFFSET_BITS-1:0]};

  assign accept = (state == IDLE) && request;

`ifdef MEMORY_CONTROLLER_RANGE_CHECK_EN
  localparam logic [WORD_BITS:0] RANGE_LIMIT = (WORD_BITS+1)'(MEMORY_WORDS) << BYTE_OFFSET_BITS;

  logic cap_range_err;

  assign ram_we = access && cap_write && !cap_range_err;
`else
  assign ram_we = access && cap_write;
`endif

  always_comb begin
    next_state = state;
    access     = 1'b0;
    case (state)
      IDLE: begin
        if (request) begin
          next_state = BUSY;
        end
      end
      BUSY: begin
        if (count == '0) begin
          next_state = RESPOND;
          access     = 1'b1;
        end
      end
      RESPOND: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Request capture, latency countdown and the registered response.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count       <= '0;
      cap_index   <= '0;
      cap_data    <= '0;
      cap_write   <= 1'b0;
      output_data <= '0;
      ready       <= 1'b0;
    end else begin
      ready <= (next_state == RESPOND);
      if (accept) begin
        cap_index <= address[ADDR_BITS+BYTE_OFFSET_BITS-1:BYTE_OFFSET_BITS];
        cap_data  <= input_data;
        cap_write <= should_write;
        count     <= CNT_BITS'(LATENCY - 1);
      end else if ((state == BUSY) && (count != '0)) begin
        count <= count - CNT_BITS'(1);
      end
      if (access) begin
`ifdef MEMORY_CONTROLLER_RANGE_CHECK_EN
        if (cap_range_err) begin
          output_data <= '0;
        end else
`endif
        if (cap_write) begin
          output_data <= cap_data;
        end else begin
          output_data <= ram_rdata;
        end
      end
    end
  end

`ifdef MEMORY_CONTROLLER_RANGE_CHECK_EN
  // The range flag is taken from the full byte address at accept time.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cap_range_err <= 1'b0;
      error         <= 1'b0;
    end else begin
      if (accept) begin
        cap_range_err <= ({1'b0, address} >= RANGE_LIMIT);
      end
      error <= access && cap_range_err;
    end
  end
`endif

  memory_controller_ram #(
    .MEMORY_WORDS(MEMORY_WORDS)
  ) u_ram (
    .clock       (clock),
    .write_enable(ram_we),
    .index       (cap_index),
    .write_data  (cap_data),
    .read_data   (ram_rdata)
  );

endmodule

// File: tb/tb_memory_controller.sv
// Scoreboard bench for memory_controller: latency, data, back-to-back, abort and aliasing.
module tb_memory_controller;

  localparam int LATENCY      = 4;
  localparam int MEMORY_WORDS = 1024;
  localparam int TIMEOUT      = 40;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        request;
  logic [31:0] address;
  logic [31:0] input_data;
  logic        should_write;
  logic [31:0] output_data;
  logic        ready;
`ifdef MEMORY_CONTROLLER_RANGE_CHECK_EN
  logic        error;
`endif

  int          errors = 0;
  int          checks = 0;
  int          cycle_count = 0;
  logic [31:0] exp_q[$];

  memory_controller #(
    .MEMORY_WORDS(MEMORY_WORDS),
    .LATENCY     (LATENCY)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .request     (request),
    .address     (address),
    .input_data  (input_data),
    .should_write(should_write),
    .output_data (output_data),
    .ready       (ready)
`ifdef MEMORY_CONTROLLER_RANGE_CHECK_EN
    ,
    .error       (error)
`endif
  );

  always #5 clock = ~clock;

  always @(posedge clock) cycle_count = cycle_count + 1;

  // Drives one request for a single accept edge; leaves the bench at the negedge after accept.
  task automatic send(input logic [31:0] a, input logic [31:0] d, input logic w,
                      input logic [31:0] exp_data, input bit track);
    @(negedge clock);
    request      = 1'b1;
    address      = a;
    input_data   = d;
    should_write = w;
    if (track) exp_q.push_back(exp_data);
    @(negedge clock);
    request = 1'b0;
  endtask

  // Waits (bounded) for ready and pops the matching scoreboard entry.
  task automatic collect(output int cyc, output bit timed_out, output logic [31:0] exp_data);
    cyc       = 0;
    timed_out = 1'b0;
    while (ready !== 1'b1) begin
      @(negedge clock);
      cyc++;
      if (cyc > TIMEOUT) begin
        timed_out = 1'b1;
        break;
      end
    end
    exp_data = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
  endtask

  task automatic test_reset();
    reset_n      = 1'b0;
    request      = 1'b0;
    address      = '0;
    input_data   = '0;
    should_write = 1'b0;
    repeat (3) @(negedge clock);
    checks++;
    if (ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_ready: got %b expected 0", ready);
    end
    checks++;
    if (output_data !== 32'h0) begin
      errors++;
      $display("[TB] FAIL reset_data: got %h expected 00000000", output_data);
    end
    reset_n = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_read_after_reset();
    int          cyc;
    bit          to;
    logic [31:0] e;
    send(32'h0000_0010, 32'h0, 1'b0, 32'h0000_0000, 1'b1);
    collect(cyc, to, e);
    checks++;
    if (to || cyc != LATENCY) begin
      errors++;
      $display("[TB] FAIL read_latency: got %0d cycles (timeout=%0b) expected %0d", cyc, to, LATENCY);
    end
    checks++;
    if (output_data !== e) begin
      errors++;
      $display("[TB] FAIL read_reset_data: got %h expected %h", output_data, e);
    end
`ifdef MEMORY_CONTROLLER_RANGE_CHECK_EN
    checks++;
    if (error !== 1'b0) begin
      errors++;
      $display("[TB] FAIL in_range_error: got %b expected 0", error);
    end
`endif
    @(negedge clock);
    checks++;
    if (ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL ready_width: got %b expected 0", ready);
    end
  endtask

  task automatic test_write_read();
    int          cyc;
    bit          to;
    logic [31:0] e;
    send(32'h0000_0010, 32'hDEAD_BEEF, 1'b1, 32'hDEAD_BEEF, 1'b1);
    collect(cyc, to, e);
    checks++;
    if (to || output_data !== e) begin
      errors++;
      $display("[TB] FAIL write_echo: got %h expected %h (timeout=%0b)", output_data, e, to);
    end
    repeat (3) @(negedge clock);
    checks++;
    if (output_data !== 32'hDEAD_BEEF) begin
      errors++;
      $display("[TB] FAIL data_hold: got %h expected deadbeef", output_data);
    end
    send(32'h0000_0012, 32'h0, 1'b0, 32'hDEAD_BEEF, 1'b1);
    collect(cyc, to, e);
    checks++;
    if (to || output_data !== e) begin
      errors++;
      $display("[TB] FAIL raw_read: got %h expected %h (timeout=%0b)", output_data, e, to);
    end
    @(negedge clock);
  endtask

  task automatic test_back_to_back();
    int          cyc;
    bit          to;
    logic [31:0] e;
    int          t1;
    int          t2;
    send(32'h4, 32'h11, 1'b1, 32'h11, 1'b1);
    collect(cyc, to, e);
    @(negedge clock);
    send(32'h8, 32'h22, 1'b1, 32'h22, 1'b1);
    collect(cyc, to, e);
    checks++;
    if (to || output_data !== e) begin
      errors++;
      $display("[TB] FAIL prewrite: got %h expected %h (timeout=%0b)", output_data, e, to);
    end
    @(negedge clock);
    request      = 1'b1;
    address      = 32'h4;
    should_write = 1'b0;
    exp_q.push_back(32'h11);
    exp_q.push_back(32'h22);
    collect(cyc, to, e);
    t1 = cycle_count;
    checks++;
    if (to || output_data !== e) begin
      errors++;
      $display("[TB] FAIL b2b_first: got %h expected %h (timeout=%0b)", output_data, e, to);
    end
    address = 32'h8;
    @(negedge clock);
    collect(cyc, to, e);
    t2 = cycle_count;
    request = 1'b0;
    checks++;
    if (to || output_data !== e) begin
      errors++;
      $display("[TB] FAIL b2b_second: got %h expected %h (timeout=%0b)", output_data, e, to);
    end
    checks++;
    if (t2 - t1 != LATENCY + 2) begin
      errors++;
      $display("[TB] FAIL b2b_spacing: got %0d cycles expected %0d", t2 - t1, LATENCY + 2);
    end
    @(negedge clock);
  endtask

  task automatic test_busy_change();
    int          cyc;
    bit          to;
    logic [31:0] e;
    send(32'h30, 32'hA5A5_0001, 1'b1, 32'hA5A5_0001, 1'b1);
    address      = 32'h40;
    input_data   = 32'hFFFF_FFFF;
    should_write = 1'b0;
    collect(cyc, to, e);
    checks++;
    if (to || output_data !== e) begin
      errors++;
      $display("[TB] FAIL busy_capture: got %h expected %h (timeout=%0b)", output_data, e, to);
    end
    @(negedge clock);
    send(32'h40, 32'h0, 1'b0, 32'h0000_0000, 1'b1);
    collect(cyc, to, e);
    checks++;
    if (to || output_data !== e) begin
      errors++;
      $display("[TB] FAIL busy_no_write: got %h expected %h (timeout=%0b)", output_data, e, to);
    end
    @(negedge clock);
    send(32'h30, 32'h0, 1'b0, 32'hA5A5_0001, 1'b1);
    collect(cyc, to, e);
    checks++;
    if (to || output_data !== e) begin
      errors++;
      $display("[TB] FAIL busy_readback: got %h expected %h (timeout=%0b)", output_data, e, to);
    end
    @(negedge clock);
  endtask

  task automatic test_reset_abort();
    int          cyc;
    bit          to;
    logic [31:0] e;
    bit          seen;
    send(32'h20, 32'h1234_5678, 1'b1, 32'h1234_5678, 1'b1);
    collect(cyc, to, e);
    @(negedge clock);
    send(32'h20, 32'hCAFE_F00D, 1'b1, 32'h0, 1'b0);
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    checks++;
    if (output_data !== 32'h0) begin
      errors++;
      $display("[TB] FAIL abort_clear: got %h expected 00000000", output_data);
    end
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    seen    = 1'b0;
    for (int i = 0; i < 2 * LATENCY + 4; i++) begin
      @(negedge clock);
      if (ready === 1'b1) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("[TB] FAIL abort_ready: got ready pulse expected none");
    end
    send(32'h20, 32'h0, 1'b0, 32'h1234_5678, 1'b1);
    collect(cyc, to, e);
    checks++;
    if (to || output_data !== e) begin
      errors++;
      $display("[TB] FAIL abort_old_value: got %h expected %h (timeout=%0b)", output_data, e, to);
    end
    @(negedge clock);
  endtask

  task automatic test_alias();
    int          cyc;
    bit          to;
    logic [31:0] e;
    send(32'h0, 32'h5555_AAAA, 1'b1, 32'h5555_AAAA, 1'b1);
    collect(cyc, to, e);
    @(negedge clock);
`ifdef MEMORY_CONTROLLER_RANGE_CHECK_EN
    send(32'h0000_1000, 32'h0, 1'b0, 32'h0, 1'b1);
    collect(cyc, to, e);
    checks++;
    if (to || output_data !== e || error !== 1'b1) begin
      errors++;
      $display("[TB] FAIL range_read: got %h err=%b expected %h err=1", output_data, error, e);
    end
    @(negedge clock);
    send(32'h0000_1004, 32'h99, 1'b1, 32'h0, 1'b1);
    collect(cyc, to, e);
    checks++;
    if (to || output_data !== e || error !== 1'b1) begin
      errors++;
      $display("[TB] FAIL range_write: got %h err=%b expected %h err=1", output_data, error, e);
    end
    @(negedge clock);
    send(32'h4, 32'h0, 1'b0, 32'h11, 1'b1);
    collect(cyc, to, e);
    checks++;
    if (to || output_data !== e) begin
      errors++;
      $display("[TB] FAIL range_ram_intact: got %h expected %h", output_data, e);
    end
`else
    send(32'h0000_1000, 32'h0, 1'b0, 32'h5555_AAAA, 1'b1);
    collect(cyc, to, e);
    checks++;
    if (to || output_data !== e) begin
      errors++;
      $display("[TB] FAIL alias_read: got %h expected %h (timeout=%0b)", output_data, e, to);
    end
`endif
    @(negedge clock);
  endtask

  initial begin
    $display("[TB] memory_controller bench start");
    test_reset();
    test_read_after_reset();
    test_write_read();
    test_back_to_back();
    test_busy_change();
    test_reset_abort();
    test_alias();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain: got %0d entries expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no completion expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
